// File: rtl/bram_s9_rd_pkg.sv
// -----------------------------------------------------------------------------
// bram_s9_rd_pkg
//   Shared types and constants for the 2K x 9 block-RAM stream reader.
//
//   state_e    : reader FSM states (IDLE, FETCH, DRAIN)
//   PAR_*      : parity-check mode encodings (any other value disables checks)
//   entry_t    : one skid-buffer slot {data, parity-error, last-of-transfer}
//   RAM_WORDS  : depth of the RAM being read
//   calc_perr  : parity-mismatch evaluation for one {DOPB, DOB} word
// -----------------------------------------------------------------------------
package bram_s9_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    localparam int unsigned RAM_WORDS = 2048;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       last;
    } entry_t;

    // Mode 3 is reserved and behaves like PAR_NONE.
    function automatic logic calc_perr(input logic [1:0] mode, input logic [8:0] word);
        logic res;
        case (mode)
            PAR_EVEN: res = ^word;
            PAR_ODD:  res = ~^word;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bram_rd_skid.sv
// -----------------------------------------------------------------------------
// bram_rd_skid
//   Two-entry registered FIFO that absorbs the RAM read latency. The head
//   entry is always slot 0, so the stream outputs come straight from flops.
//
//   clk_i         : clock
//   rst_ni        : asynchronous active-low reset (FIFO empty)
//   push_i        : write push_entry_i this cycle
//   push_entry_i  : entry to write
//   pop_i         : remove the head entry this cycle (ignored when empty)
//   head_entry_o  : current head entry (meaningful when occupancy_o != 0)
//   occupancy_o   : number of stored entries, 0..2
// -----------------------------------------------------------------------------
module bram_rd_skid
    import bram_s9_rd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  entry_t     push_entry_i,
    input  logic       pop_i,
    output entry_t     head_entry_o,
    output logic [1:0] occupancy_o
);

    entry_t     ent0_q, ent0_d;
    entry_t     ent1_q, ent1_d;
    logic [1:0] occ_q,  occ_d;

    logic pop_ok;
    logic push_ok;

    assign pop_ok  = pop_i && (occ_q != 2'd0);
    // A push into a full FIFO is only legal when a pop frees a slot.
    assign push_ok = push_i && ((occ_q != 2'd2) || pop_ok);

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_d = push_entry_i;
                end else begin
                    ent1_d = push_entry_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands behind whatever
                // remains after the head leaves.
                if (occ_q == 2'd1) begin
                    ent0_d = push_entry_i;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_entry_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_entry_o = ent0_q;
    assign occupancy_o  = occ_q;

endmodule

// File: rtl/bram_s9_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_s9_stream_reader
//   Reads LEN consecutive 9-bit words (8 data + 1 parity) from a 2K x 9 block
//   RAM read port starting at BASE_ADDR and emits them as a valid/ready byte
//   stream, checking the stored parity bit on every word.
//
//   CLK, RST_N      : clock, asynchronous active-low reset
//   START           : request a transfer (ignored while BUSY, with LEN == 0,
//                     or in the DONE cycle)
//   BASE_ADDR, LEN  : first address and word count, sampled on accepted START
//   BUSY, DONE      : transfer in progress / one-cycle completion pulse
//   ADDRB, ENB      : RAM read address and enable
//   DOB, DOPB       : RAM read data and parity, valid the cycle after ENB
//   M_DATA, M_PERR  : stream byte and its parity-mismatch sideband
//   M_VALID/M_READY : stream handshake
//   M_LAST          : final byte of the transfer
//   PAR_ERR         : sticky mismatch flag for the current transfer
// -----------------------------------------------------------------------------
module bram_s9_stream_reader
    import bram_s9_rd_pkg::*;
#(
    parameter logic [1:0]  PARITY_MODE = 2'd1,
    parameter int unsigned ADDR_W      = 11
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W:0]   LEN,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] ADDRB,
    output logic              ENB,
    input  logic [7:0]        DOB,
    input  logic              DOPB,
    output logic [7:0]        M_DATA,
    output logic              M_PERR,
    output logic              M_VALID,
    input  logic              M_READY,
    output logic              M_LAST,
    output logic              PAR_ERR
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_issue_q;
    logic [ADDR_W:0]   rem_out_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              par_err_q;
    logic              done_q;

    logic       issue;
    logic       pop;
    logic       push;
    logic       perr;
    logic [1:0] occ;
    entry_t     push_entry;
    entry_t     head_entry;

    // Registered occupancy plus the outstanding read must leave room for the
    // word this issue will return, so the skid buffer can never overflow.
    assign issue = (state_q == FETCH) && (rem_issue_q != '0)
                   && (({1'b0, occ} + {2'b00, inflight_q}) < 3'd2);

    assign push = inflight_q;
    assign perr = calc_perr(PARITY_MODE, {DOPB, DOB});

    assign push_entry.data = DOB;
    assign push_entry.perr = perr;
    assign push_entry.last = inflight_last_q;

    assign pop = M_VALID && M_READY;

    bram_rd_skid u_skid (
        .clk_i        (CLK),
        .rst_ni       (RST_N),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_entry_o (head_entry),
        .occupancy_o  (occ)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_issue_q     <= '0;
            rem_out_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            par_err_q       <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            done_q          <= 1'b0;
            inflight_q      <= issue;
            // The word issued with one remaining is the one that carries LAST.
            inflight_last_q <= issue && (rem_issue_q == {{ADDR_W{1'b0}}, 1'b1});

            if (push && perr) begin
                par_err_q <= 1'b1;
            end

            if (issue) begin
                addr_q      <= addr_q + 1'b1;
                rem_issue_q <= rem_issue_q - 1'b1;
            end

            if (pop) begin
                rem_out_q <= rem_out_q - 1'b1;
            end

            case (state_q)
                IDLE: begin
                    // done_q blocks a START that coincides with the DONE pulse.
                    if (START && (LEN != '0) && !done_q) begin
                        addr_q      <= BASE_ADDR;
                        rem_issue_q <= LEN;
                        rem_out_q   <= LEN;
                        par_err_q   <= 1'b0;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    if (issue && (rem_issue_q == {{ADDR_W{1'b0}}, 1'b1})) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (rem_out_q == {{ADDR_W{1'b0}}, 1'b1})) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;
    assign ADDRB   = addr_q;
    assign ENB     = issue;
    assign M_VALID = (occ != 2'd0);
    assign M_DATA  = head_entry.data;
    assign M_PERR  = head_entry.perr;
    assign M_LAST  = head_entry.last;
    assign PAR_ERR = par_err_q;

endmodule

// File: tb/tb_bram_s9_stream_reader.sv
module tb_bram_s9_stream_reader;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [10:0] BASE_ADDR;
    logic [11:0] LEN;
    logic        M_READY;

    logic        BUSY, DONE, ENB, M_PERR, M_VALID, M_LAST, PAR_ERR;
    logic [10:0] ADDRB;
    logic [7:0]  M_DATA;
    logic [7:0]  DOB;
    logic        DOPB;

    logic        BUSY0, DONE0, ENB0, M_PERR0, M_VALID0, M_LAST0, PAR_ERR0;
    logic [10:0] ADDRB0;
    logic [7:0]  M_DATA0;
    logic [7:0]  DOB0;
    logic        DOPB0;

    logic [8:0] ram [0:2047];
    logic [8:0] rd1_q;
    logic [8:0] rd0_q;

    int total;
    int bad;

    bram_s9_stream_reader #(.PARITY_MODE(2'd1)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .ADDRB(ADDRB), .ENB(ENB), .DOB(DOB), .DOPB(DOPB),
        .M_DATA(M_DATA), .M_PERR(M_PERR), .M_VALID(M_VALID), .M_READY(M_READY),
        .M_LAST(M_LAST), .PAR_ERR(PAR_ERR)
    );

    bram_s9_stream_reader #(.PARITY_MODE(2'd0)) dut_p0 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
        .BUSY(BUSY0), .DONE(DONE0), .ADDRB(ADDRB0), .ENB(ENB0), .DOB(DOB0), .DOPB(DOPB0),
        .M_DATA(M_DATA0), .M_PERR(M_PERR0), .M_VALID(M_VALID0), .M_READY(M_READY),
        .M_LAST(M_LAST0), .PAR_ERR(PAR_ERR0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM read ports: registered, one cycle of latency.
    always @(posedge CLK) if (ENB)  rd1_q <= ram[ADDRB];
    always @(posedge CLK) if (ENB0) rd0_q <= ram[ADDRB0];
    assign DOB   = rd1_q[7:0];
    assign DOPB  = rd1_q[8];
    assign DOB0  = rd0_q[7:0];
    assign DOPB0 = rd0_q[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int unsigned base;
        int unsigned len;
        int unsigned rdy;       // 0 = always ready, 1 = 1,0,0,1,0,1 pattern, 2 = random
        bit          flip5;     // corrupt the parity bit of address 5
        bit          busy_start;
        bit          start_on_done;
        int unsigned exp_last;  // last RAM address read
        bit          exp_par;   // PAR_ERR after DONE
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input vec_t v);
        int unsigned idx, issued, first_c, last_pop_c, occ_m, infl_m, budget;
        int unsigned last_addr;
        bit          done_seen, pop, rdy;
        bit          pat [6];
        logic [8:0]  w;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0; issued = 0; first_c = 0; last_pop_c = 0; occ_m = 0; infl_m = 0;
        last_addr = 0; done_seen = 0;
        budget = v.len * 4 + 50;
        if (v.flip5) ram[5][8] = ~ram[5][8];
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = v.base[10:0]; LEN = v.len[11:0]; M_READY = 1'b0;
        for (int unsigned c = 1; c <= budget && !done_seen; c++) begin
            @(negedge CLK);
            if (v.busy_start && c == 2) begin
                START = 1'b1; BASE_ADDR = 11'd1000; LEN = 12'd5;
            end else begin
                START = 1'b0;
            end
            case (v.rdy)
                0:       rdy = 1'b1;
                1:       rdy = pat[c % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            M_READY = rdy;
            if (c == 1) begin
                chk("busy_after_start", BUSY, 1);
                chk("par_err_cleared", PAR_ERR, 0);
                chk("enb_first", ENB, 1);
            end
            if (M_VALID && first_c == 0) first_c = c;
            chk("valid_vs_occ", M_VALID, (occ_m != 0) ? 1 : 0);
            if (occ_m + infl_m >= 2) chk("enb_rule", ENB, 0);
            if (ENB) begin
                chk("addrb", ADDRB, (v.base + issued) % 2048);
                last_addr = ADDRB;
                issued++;
            end
            pop = 1'b0;
            if (M_VALID) begin
                if (idx < v.len) begin
                    w = ram[(v.base + idx) % 2048];
                    chk("m_data", M_DATA, w[7:0]);
                    chk("m_perr", M_PERR, ^w);
                    chk("m_last", M_LAST, (idx == v.len - 1) ? 1 : 0);
                    pop = rdy;
                    if (pop) begin
                        last_pop_c = c;
                        idx++;
                    end
                end else begin
                    chk("extra_byte", M_VALID, 0);
                end
            end
            if (M_VALID0) chk("p0_m_perr", M_PERR0, 0);
            if (DONE) begin
                chk("done_timing", c, last_pop_c + 1);
                chk("done_count", idx, v.len);
                chk("busy_at_done", BUSY, 0);
                done_seen = 1'b1;
                if (v.start_on_done) begin
                    START = 1'b1; BASE_ADDR = 11'd300; LEN = 12'd4;
                end
            end
            occ_m  = occ_m + infl_m - (pop ? 1 : 0);
            infl_m = ENB ? 1 : 0;
        end
        chk("done_seen", done_seen, 1);
        chk("first_valid_latency", first_c, 3);
        chk("issued_count", issued, v.len);
        chk("last_addr", last_addr, v.exp_last);
        chk("par_err_sticky", PAR_ERR, v.exp_par);
        chk("p0_par_err", PAR_ERR0, 0);
        @(negedge CLK);
        START = 1'b0;
        M_READY = 1'b0;
        chk("idle_busy", BUSY, 0);
        chk("idle_enb", ENB, 0);
        chk("par_err_hold", PAR_ERR, v.exp_par);
        if (v.flip5) ram[5][8] = ~ram[5][8];
    endtask

    initial begin
        int unsigned pops;
        total = 0; bad = 0;
        for (int unsigned a = 0; a < 2048; a++) begin
            logic [7:0] d;
            d = a[7:0] ^ a[10:3];
            ram[a] = {^d, d};
        end
        //          base  len   rdy flip bsy sod last par
        vecs[0] = '{0,    16,   0,  0,   0,  0,  15,  0};
        vecs[1] = '{2046, 4,    0,  0,   0,  0,  1,   0};
        vecs[2] = '{0,    8,    1,  0,   0,  0,  7,   0};
        vecs[3] = '{0,    8,    0,  1,   0,  0,  7,   1};
        vecs[4] = '{20,   6,    2,  0,   1,  0,  25,  0};
        vecs[5] = '{100,  2048, 0,  0,   0,  1,  99,  0};

        RST_N = 1'b0; START = 1'b0; BASE_ADDR = '0; LEN = '0; M_READY = 1'b0;
        #12;
        chk("reset_outputs", {BUSY, DONE, ADDRB, ENB, M_DATA, M_PERR, M_VALID, M_LAST, PAR_ERR}, 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // LEN = 0 is ignored.
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = 11'd7; LEN = 12'd0;
        @(negedge CLK);
        START = 1'b0;
        chk("len0_busy", BUSY, 0);
        chk("len0_enb", ENB, 0);
        @(negedge CLK);
        chk("len0_busy_later", BUSY, 0);

        for (int unsigned i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abort a 10-word transfer after three bytes have been presented.
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = 11'd0; LEN = 12'd10; M_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        pops = 0;
        for (int unsigned c = 0; c < 40 && pops < 3; c++) begin
            @(negedge CLK);
            if (M_VALID) pops++;
        end
        chk("abort_reached_byte3", pops, 3);
        #2 RST_N = 1'b0;
        #1;
        chk("async_reset_outputs", {BUSY, DONE, ADDRB, ENB, M_DATA, M_PERR, M_VALID, M_LAST, PAR_ERR}, 0);
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("reset_no_done", DONE, 0);
        end
        RST_N = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("post_reset_idle", {BUSY, DONE, ENB, M_VALID}, 0);
        end
        run_vec('{40, 2, 0, 0, 0, 0, 41, 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
